// File: rtl/can_bit_destuffer_if.sv
// -----------------------------------------------------------------------------
// can_bit_destuffer_if
//
// Purpose:
//   Groups the sample-side inputs and the destuffed-side outputs of the CAN bit
//   destuffer into one bundle. The bit-timing logic drives the inputs and the
//   frame shift register consumes the outputs.
//
// Signals:
//   sp          sample-point strobe, one clk wide, at most once per bit time
//   CAN_RX      synchronised bus level (0 dominant, 1 recessive), valid on sp
//   enable      stuffing region active (SOF through CRC sequence)
//   sof_clear   single-cycle pulse that restarts run tracking at frame start
//   isStuff     1 = the next sampled bit is a stuff bit and must be discarded
//   bit_out     last non-stuff sampled bit
//   bit_valid   one-cycle pulse per non-stuff bit, the cycle after sp
//   stuff_error one-cycle pulse on a stuff-rule violation
//   error_flag  sticky stuff-error indication
//   run_count   current length of the identical-bit run
//
// Modports:
//   master  the bit-timing side (drives sp/CAN_RX/enable/sof_clear)
//   slave   the destuffer itself
// -----------------------------------------------------------------------------
interface can_bit_destuffer_if #(
    parameter int CNT_W = 3
);
    logic             sp;
    logic             CAN_RX;
    logic             enable;
    logic             sof_clear;
    logic             isStuff;
    logic             bit_out;
    logic             bit_valid;
    logic             stuff_error;
    logic             error_flag;
    logic [CNT_W-1:0] run_count;

    modport master (
        output sp,
        output CAN_RX,
        output enable,
        output sof_clear,
        input  isStuff,
        input  bit_out,
        input  bit_valid,
        input  stuff_error,
        input  error_flag,
        input  run_count
    );

    modport slave (
        input  sp,
        input  CAN_RX,
        input  enable,
        input  sof_clear,
        output isStuff,
        output bit_out,
        output bit_valid,
        output stuff_error,
        output error_flag,
        output run_count
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// -----------------------------------------------------------------------------
// can_bit_destuffer
//
// Purpose:
//   Sits in front of the frame shift register in the CAN receive path. On each
//   sample-point strobe it tracks runs of identical bits; after STUFF_WIDTH equal
//   bits it raises isStuff so the next bit (the stuff bit) is dropped, checks
//   that the stuff bit has the opposite polarity, and flags a stuff error when
//   it does not. Non-stuff bits are presented on bit_out with a bit_valid pulse.
//
// Parameters:
//   STUFF_WIDTH  equal bits after which a stuff bit follows (legal 2..7)
//   CNT_W        run counter width; must be able to hold STUFF_WIDTH
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      can_bit_destuffer_if.slave (see interface header for signals)
//
// All outputs are registered and settle one clk after the sp cycle, so they
// are stable well before the next sample point.
// -----------------------------------------------------------------------------
module can_bit_destuffer #(
    parameter int STUFF_WIDTH = 5,
    parameter int CNT_W       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    can_bit_destuffer_if.slave    bus
);

    localparam logic [CNT_W-1:0] STUFF_LIMIT = CNT_W'(STUFF_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // outside the stuffing region, or freshly cleared
        ST_COUNT  = 2'd1,   // tracking a run of identical bits
        ST_EXPECT = 2'd2,   // next sampled bit is the stuff bit
        ST_ERROR  = 2'd3    // stuff rule violated; bits pass through uncounted
    } state_t;

    state_t           state_q,       state_d;
    logic [CNT_W-1:0] run_count_q,   run_count_d;
    logic             last_bit_q,    last_bit_d;
    logic             is_stuff_q,    is_stuff_d;
    logic             bit_out_q,     bit_out_d;
    logic             bit_valid_q,   bit_valid_d;
    logic             stuff_error_q, stuff_error_d;
    logic             error_flag_q,  error_flag_d;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        run_count_d   = run_count_q;
        last_bit_d    = last_bit_q;
        is_stuff_d    = is_stuff_q;
        bit_out_d     = bit_out_q;
        error_flag_d  = error_flag_q;
        bit_valid_d   = 1'b0;
        stuff_error_d = 1'b0;

        // Frame-start clear is applied first; a coincident sp then sees the
        // cleared context and starts a new run with the sampled bit.
        if (bus.sof_clear) begin
            run_count_d  = '0;
            is_stuff_d   = 1'b0;
            error_flag_d = 1'b0;
            state_d      = bus.enable ? ST_COUNT : ST_IDLE;
        end

        if (bus.sp) begin
            if (state_d == ST_ERROR) begin
                // Only sof_clear or reset leaves ERROR, even across enable
                // changes; bits keep flowing so the frame can be drained.
                bit_valid_d = 1'b1;
                bit_out_d   = bus.CAN_RX;
            end else if (!bus.enable) begin
                // Outside the stuffing region: plain pass-through. A stuff bit
                // that was pending here is simply abandoned, without error.
                bit_valid_d = 1'b1;
                bit_out_d   = bus.CAN_RX;
                run_count_d = '0;
                is_stuff_d  = 1'b0;
                state_d     = ST_IDLE;
            end else if (state_d == ST_EXPECT) begin
                // The current bit is the stuff bit: never forwarded.
                is_stuff_d = 1'b0;
                if (bus.CAN_RX != last_bit_q) begin
                    // Legal stuff bit opens the next run as its first bit.
                    last_bit_d  = bus.CAN_RX;
                    run_count_d = CNT_ONE;
                    state_d     = ST_COUNT;
                end else begin
                    stuff_error_d = 1'b1;
                    error_flag_d  = 1'b1;
                    run_count_d   = '0;
                    state_d       = ST_ERROR;
                end
            end else begin
                // IDLE / COUNT: ordinary data bit.
                bit_valid_d = 1'b1;
                bit_out_d   = bus.CAN_RX;
                // A zero count means no run is open, so last_bit is stale and
                // must not extend anything.
                if ((run_count_d != '0) && (bus.CAN_RX == last_bit_q)) begin
                    run_count_d = run_count_d + CNT_ONE;
                end else begin
                    run_count_d = CNT_ONE;
                    last_bit_d  = bus.CAN_RX;
                end
                // Reaching the limit always moves to EXPECT, which is what
                // keeps run_count from ever passing STUFF_WIDTH.
                if (run_count_d == STUFF_LIMIT) begin
                    is_stuff_d = 1'b1;
                    state_d    = ST_EXPECT;
                end else begin
                    state_d    = ST_COUNT;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            run_count_q   <= '0;
            last_bit_q    <= 1'b1;
            is_stuff_q    <= 1'b0;
            bit_out_q     <= 1'b1;
            bit_valid_q   <= 1'b0;
            stuff_error_q <= 1'b0;
            error_flag_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values of the others, regardless of statement order.
            state_q       <= state_d;
            run_count_q   <= run_count_d;
            last_bit_q    <= last_bit_d;
            is_stuff_q    <= is_stuff_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            stuff_error_q <= stuff_error_d;
            error_flag_q  <= error_flag_d;
        end
    end

    assign bus.isStuff     = is_stuff_q;
    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.stuff_error = stuff_error_q;
    assign bus.error_flag  = error_flag_q;
    assign bus.run_count   = run_count_q;

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
- Upstream neighbour of the frame shift register in the CAN receive path.
- Watches sampled CAN_RX bits on each sample-point strobe and counts runs of identical bits.
- Raises isStuff so the downstream storage skips the inserted stuff bit.
- Checks each stuff bit for polarity and flags stuff errors. Also presents destuffed data bits with a valid strobe.

Parameters:
STUFF_WIDTH, 5, number of consecutive identical bits after which a stuff bit is inserted (legal range 2..7)
CNT_W, 3, width of the run counter; must hold STUFF_WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
sp  input  1  sample-point strobe, one clk cycle wide, at most once per bit time
CAN_RX  input  1  synchronised bus level (0 dominant, 1 recessive); valid when sp=1
enable  input  1  stuffing region active (SOF through CRC sequence); sampled on sp
sof_clear  input  1  single-cycle pulse that restarts run tracking at frame start
isStuff  output  1  registered; 1 means the next sampled bit is a stuff bit and must be discarded
bit_out  output  1  registered copy of the last non-stuff sampled bit
bit_valid  output  1  one-cycle pulse, the cycle after sp, for each non-stuff bit
stuff_error  output  1  one-cycle pulse on a stuff-rule violation
error_flag  output  1  sticky stuff-error indication; cleared by sof_clear or reset
run_count  output  CNT_W  current length of the identical-bit run (debug/observability)

Behaviour:
- Reset (reset_n=0, asynchronous): isStuff=0, bit_out=1, bit_valid=0, stuff_error=0, error_flag=0, run_count=0, last_bit=1, state=IDLE.
- States:
  - IDLE: enable=0 or just cleared.
  - COUNT: tracking a run.
  - EXPECT: isStuff=1.
  - ERROR: error_flag=1.
- All transitions occur only on a clk edge with sp=1, except sof_clear.
- sof_clear (any cycle): run_count←0, isStuff←0, error_flag←0, state←COUNT if enable else IDLE.
  - If sp=1 in the same cycle, the clear applies first. The sampled bit is then processed as the first bit of a new run: run_count=1, last_bit=CAN_RX, bit_valid pulses.
- sp with enable=0:
  - bit_valid pulses and bit_out=CAN_RX.
  - run_count←0, isStuff←0, state←IDLE.
  - error_flag is held.
- sp with enable=1, state COUNT/IDLE (isStuff=0):
  - bit_valid pulses next cycle and bit_out←CAN_RX.
  - If run_count>0 and CAN_RX==last_bit: run_count←run_count+1. Otherwise run_count←1 and last_bit←CAN_RX.
  - When the new run_count equals STUFF_WIDTH: isStuff←1, state←EXPECT.
  - run_count never exceeds STUFF_WIDTH.
- sp with enable=1, state EXPECT (current bit is the stuff bit):
  - No bit_valid pulse.
  - If CAN_RX != last_bit (legal stuff bit): last_bit←CAN_RX, run_count←1, isStuff←0, state←COUNT. The stuff bit counts as the first bit of the next run.
  - If CAN_RX == last_bit: stuff_error pulses one cycle, error_flag←1, isStuff←0, run_count←0, state←ERROR.
- ERROR:
  - No counting and isStuff stays 0.
  - bit_valid still pulses per sp, passing bits through.
  - Exit only by sof_clear or reset.
- enable dropping while in EXPECT: the pending stuff bit is abandoned (isStuff←0) at the next sp, with no error.
- Latency: isStuff, bit_out, bit_valid and stuff_error are all registered and settle exactly one clk after the sp cycle. They are therefore stable before the next sp.
- Reset asserted mid-frame aborts immediately. The first sp after release is treated as the first bit in IDLE/COUNT rules.
- sp pulses closer than 2 clk apart are outside the contract.

Test Plan:
- Reset release, sof_clear, enable=1, bits 0,0,0,0,0 → run_count 1..5; isStuff=1 one clk after the 5th sp. Next bit 1 → isStuff=0, run_count=1, no bit_valid for that bit.
- Bits 1,1,1,1,1 then 1 with enable=1 → stuff_error pulses exactly one clk, error_flag=1 and stays high over 10 further sp. sof_clear → error_flag=0.
- Bits 0×5, stuff 1, then 1,1,1,1 → isStuff asserts after the 4th following 1 (stuff bit counted in run); run_count=5.
- Alternating 0,1 for 20 bits → isStuff never asserts, run_count toggles at 1, 20 bit_valid pulses.
- enable=0 with 8 identical bits → no isStuff, run_count=0, 8 bit_valid pulses with bit_out following CAN_RX.
- reset_n low mid-run at run_count=3 → all outputs at reset values immediately. sof_clear coincident with sp on CAN_RX=0 → run_count=1, last_bit=0, bit_valid pulses.
